msi_irq_arbiter: RTL and testbench

MSI_IRQ_ARBITER -- requirements
Module: msi_irq_arbiter

---
 rtl/msi_irq_arbiter.sv | 75 +++++++
 tb/tb_msi_irq_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/msi_irq_arbiter.sv
// msi_irq_arbiter: round-robin MSI request arbiter over edge/level interrupt sources; define MSI_IRQ_DROPCNT_EN for per-source drop counters
module msi_irq_arbiter #(
  parameter int N_SRC = 4,
  parameter logic [N_SRC-1:0] LEVEL_MASK = '0,
  localparam int VEC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             axi_clk_pcie,
  input  logic             sys_reset,
  input  logic [N_SRC-1:0] irq_i,
  input  logic             msi_enabled,
  input  logic             msi_grant,
  output logic             msi_request,
  output logic [VEC_W-1:0] msi_vector,
`ifdef MSI_IRQ_DROPCNT_EN
  output logic [N_SRC*16-1:0] drop_cnt,
`endif
  output logic [N_SRC-1:0] pending_o
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic [N_SRC-1:0] irq_p_q, pending_q, pending_d, fire, clr;
  logic [VEC_W-1:0] vec_q, vec_d, last_q, last_d, pick;
  assign fire = (irq_i & ~irq_p_q & ~LEVEL_MASK) | (irq_i & LEVEL_MASK);
  assign pending_d = (pending_q & ~clr) | fire;
  assign msi_request = (state_q == REQ);
  assign msi_vector = vec_q;
  assign pending_o = pending_q;
  always_comb begin
    pick = '0;
    for (int k = N_SRC; k >= 1; k--) pick = pending_q[(int'(last_q) + k) % N_SRC] ? VEC_W'((int'(last_q) + k) % N_SRC) : pick;
  end
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    last_d = last_q;
    clr = '0;
    if (state_q == IDLE) begin
      if (msi_enabled && |pending_q) begin
        state_d = REQ;
        vec_d = pick;
      end
    end else if (msi_grant) begin
      clr[vec_q] = 1'b1;
      last_d = vec_q;
      state_d = IDLE;
    end else if (!msi_enabled) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge axi_clk_pcie)
    if (sys_reset) begin
      state_q <= IDLE;
      irq_p_q <= '0;
      pending_q <= '0;
      vec_q <= '0;
      last_q <= VEC_W'(N_SRC - 1);
    end else begin
      state_q <= state_d;
      irq_p_q <= irq_i;
      pending_q <= pending_d;
      vec_q <= vec_d;
      last_q <= last_d;
    end
`ifdef MSI_IRQ_DROPCNT_EN
  logic [N_SRC*16-1:0] drop_q, drop_d;
  always_comb begin
    drop_d = drop_q;
    for (int i = 0; i < N_SRC; i++)
      drop_d[i*16 +: 16] = (fire[i] && pending_q[i] && drop_q[i*16 +: 16] != 16'hFFFF) ? drop_q[i*16 +: 16] + 16'd1 : drop_q[i*16 +: 16];
  end
  always_ff @(posedge axi_clk_pcie)
    drop_q <= sys_reset ? '0 : drop_d;
  assign drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_msi_irq_arbiter.sv
// tb_msi_irq_arbiter: scoreboard bench with a behavioural arbiter model and random traffic
module tb_msi_irq_arbiter;
  localparam logic [3:0] LVL = 4'b0001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] irq = '0;
  logic en = 1'b0;
  logic gnt = 1'b0;
  logic req;
  logic [1:0] vec;
  logic [3:0] pend;
`ifdef MSI_IRQ_DROPCNT_EN
  logic [63:0] drop_cnt;
`endif
  msi_irq_arbiter #(.N_SRC(4), .LEVEL_MASK(LVL)) dut (
    .axi_clk_pcie(clk),
    .sys_reset(rst),
    .irq_i(irq),
    .msi_enabled(en),
    .msi_grant(gnt),
    .msi_request(req),
    .msi_vector(vec),
`ifdef MSI_IRQ_DROPCNT_EN
    .drop_cnt(drop_cnt),
`endif
    .pending_o(pend)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit started = 0;
  bit m_req = 0;
  int m_vec = 0;
  int m_last = 3;
  bit m_pend[4];
  bit m_prev[4];
  int m_drop[4];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int pend_word();
    int w = 0;
    for (int i = 0; i < 4; i++) if (m_pend[i]) w += (1 << i);
    return w;
  endfunction
  task automatic model(input logic [3:0] i_irq, input bit i_en, input bit i_gnt, input bit i_rst);
    bit f[4];
    bit clr[4];
    for (int i = 0; i < 4; i++) begin
      f[i] = i_irq[i] && (LVL[i] || !m_prev[i]);
      clr[i] = 0;
    end
    if (i_rst) begin
      m_req = 0;
      m_vec = 0;
      m_last = 3;
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0;
        m_prev[i] = 0;
        m_drop[i] = 0;
      end
      return;
    end
    for (int i = 0; i < 4; i++) if (f[i] && m_pend[i] && m_drop[i] < 65535) m_drop[i]++;
    if (m_req) begin
      if (i_gnt) begin
        clr[m_vec] = 1;
        m_last = m_vec;
        m_req = 0;
      end else if (!i_en) m_req = 0;
    end else if (i_en && pend_word() != 0) begin
      for (int k = 1; k <= 4; k++)
        if (m_pend[(m_last + k) % 4]) begin
          m_vec = (m_last + k) % 4;
          break;
        end
      m_req = 1;
      exp_q.push_back(m_vec);
    end
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = (m_pend[i] && !clr[i]) || f[i];
      m_prev[i] = i_irq[i];
    end
  endtask
  task automatic drive(input logic [3:0] i_irq, input bit i_en, input bit i_gnt, input bit i_rst);
    @(negedge clk);
    #1;
    irq = i_irq;
    en = i_en;
    gnt = i_gnt;
    rst = i_rst;
    model(i_irq, i_en, i_gnt, i_rst);
    started = 1;
  endtask
  task automatic idle(input int n, input bit i_en, input bit auto_gnt);
    for (int c = 0; c < n; c++) drive(4'b0000, i_en, auto_gnt && m_req, 0);
  endtask
  initial begin : monitor
    bit prev_req = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("msi_request", int'(req), int'(m_req));
        chk("pending_o", int'(pend), pend_word());
`ifdef MSI_IRQ_DROPCNT_EN
        for (int i = 0; i < 4; i++) chk("drop_cnt", int'(drop_cnt[i*16 +: 16]), m_drop[i]);
`endif
        if (req && !prev_req) begin
          if (exp_q.size() == 0) chk("unexpected_request", 1, 0);
          else chk("request_vector", int'(vec), exp_q.pop_front());
        end else if (req) chk("vector_stable", int'(vec), m_vec);
        prev_req = req;
      end
    end
  end
  initial begin : stimulus
    for (int c = 0; c < 3; c++) drive(4'b0000, 0, 0, 1);
    idle(6, 1, 0);
    drive(4'b0010, 1, 0, 0);
    idle(4, 1, 0);
    drive(4'b0000, 1, 1, 0);
    idle(4, 1, 0);
    drive(4'b1011, 1, 0, 0);
    idle(20, 1, 1);
    drive(4'b1100, 0, 0, 0);
    idle(5, 0, 0);
    idle(15, 1, 1);
    drive(4'b0001, 1, 0, 0);
    idle(3, 1, 0);
    idle(2, 0, 0);
    idle(10, 1, 1);
    drive(4'b0010, 1, 0, 0);
    drive(4'b0000, 1, 0, 0);
    drive(4'b0010, 1, 0, 0);
    drive(4'b0000, 1, 0, 0);
    drive(4'b0010, 1, 0, 0);
    idle(8, 1, 1);
    for (int c = 0; c < 15; c++) drive(4'b0001, 1, m_req, 0);
    idle(8, 1, 1);
    for (int c = 0; c < 4000; c++)
      drive(4'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
    idle(30, 1, 1);
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
